tpu_seq_ctrl: RTL

Top-level sequencer for the 8x8 output-stationary systolic array in tpu_top. On a one-cycle tpu_start pulse it sweeps read addresses over the weight SRAMs (w0/w1) and data SRAMs (d0/d1), which hold three pre-skewed batches. It then drives array enable/clear and drain timing, writes the 15 result diagonals of each batch to the three 16x128b output SRAMs (a/b/c), and raises tpu_done. It contains no datapath; write data comes from the array's diagonal mux, which this block selects.

---
 rtl/tpu_seq_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl: top-level sequencer for the 8x8 output-stationary systolic array.
// A one-cycle tpu_start sweeps the input SRAM read addresses, enables the array
// through feed and drain, then steps the diagonal mux while strobing the three
// output SRAMs, and finally holds tpu_done until srst or the next start.
//
// Ports:
//   clk                      clock, rising edge
//   srst                     synchronous reset, active-high
//   tpu_start                one-cycle start pulse (ignored while busy)
//   sram_raddr_w0/w1/d0/d1   input SRAM read addresses
//   arr_clear                one-cycle accumulator clear
//   arr_en                   array shift/MAC enable
//   diag_sel                 diagonal index to the array output mux
//   sram_write_enable_a0/b0/c0  output SRAM write strobes, active-low
//   sram_waddr_a/b/c         output SRAM write addresses
//   tpu_done                 completion level
// All outputs are registered.
module tpu_seq_ctrl #(
    parameter int unsigned ARRAY_SIZE = 8,
    parameter int unsigned NUM_BATCH  = 3,
    parameter int unsigned SKEW       = 3,
    parameter int unsigned SRAM_LAT   = 1,
    parameter int unsigned DRAIN_LEN  = 15,
    parameter int unsigned RADDR_W    = 10,
    parameter int unsigned WADDR_W    = 6
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               tpu_start,
    output logic [RADDR_W-1:0] sram_raddr_w0,
    output logic [RADDR_W-1:0] sram_raddr_w1,
    output logic [RADDR_W-1:0] sram_raddr_d0,
    output logic [RADDR_W-1:0] sram_raddr_d1,
    output logic               arr_clear,
    output logic               arr_en,
    output logic [3:0]         diag_sel,
    output logic               sram_write_enable_a0,
    output logic               sram_write_enable_b0,
    output logic               sram_write_enable_c0,
    output logic [WADDR_W-1:0] sram_waddr_a,
    output logic [WADDR_W-1:0] sram_waddr_b,
    output logic [WADDR_W-1:0] sram_waddr_c,
    output logic               tpu_done
);

    localparam int unsigned FEED_LEN = NUM_BATCH * ARRAY_SIZE + SKEW;
    localparam int unsigned DIAG_NUM = 2 * ARRAY_SIZE - 1;
    localparam int unsigned CNT_MAX  = (DRAIN_LEN > DIAG_NUM) ? DRAIN_LEN : DIAG_NUM;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned DLY_W    = (SRAM_LAT > 1) ? SRAM_LAT - 1 : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [RADDR_W-1:0] rd_cnt, rd_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               clear_q, clear_nxt;
    logic               en_q, en_nxt;
    logic               we_q, we_nxt;
    logic [WADDR_W-1:0] waddr_q, waddr_nxt;
    logic [3:0]         diag_q, diag_nxt;
    logic               done_q, done_nxt;
    logic               issue;
    logic               issue_dly;
    logic               in_write;

    // A read is issued in every FEED cycle.
    assign issue = (state == FEED);

    // Read-issue flag delayed so that arr_en(n) = issue(n - SRAM_LAT) once registered.
    if (SRAM_LAT > 1) begin : g_lat_pipe
        logic [DLY_W-1:0] dly;

        always_ff @(posedge clk) begin
            if (srst) begin
                dly <= '0;
            end else begin
                dly <= DLY_W'({dly, issue});
            end
        end

        assign issue_dly = dly[DLY_W-1];
    end else begin : g_lat_direct
        assign issue_dly = issue;
    end

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            cnt     <= '0;
            clear_q <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b1;
            waddr_q <= '0;
            diag_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_cnt  <= rd_nxt;
            cnt     <= cnt_nxt;
            clear_q <= clear_nxt;
            en_q    <= en_nxt;
            we_q    <= we_nxt;
            waddr_q <= waddr_nxt;
            diag_q  <= diag_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next state, counters, and next values of the output registers.
    always_comb begin
        state_nxt = state;
        rd_nxt    = rd_cnt;
        cnt_nxt   = cnt;
        clear_nxt = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (tpu_start) begin
                    state_nxt = FEED;
                    rd_nxt    = '0;
                    cnt_nxt   = '0;
                    clear_nxt = 1'b1;
                end
            end
            FEED: begin
                // Address holds at its last value through DRAIN and WRITE.
                if (rd_cnt == RADDR_W'(FEED_LEN - 1)) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    rd_nxt = rd_cnt + RADDR_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(DRAIN_LEN - 1)) begin
                    state_nxt = WRITE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WRITE: begin
                if (cnt == CNT_W'(DIAG_NUM - 1)) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    rd_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                rd_nxt    = '0;
                cnt_nxt   = '0;
            end
        endcase

        in_write  = (state_nxt == WRITE);
        we_nxt    = ~in_write;
        waddr_nxt = in_write ? WADDR_W'(cnt_nxt) : '0;
        diag_nxt  = in_write ? 4'(cnt_nxt) : 4'd0;
        done_nxt  = (state_nxt == DONE);
        en_nxt    = issue_dly | (state_nxt == DRAIN);
    end

    assign sram_raddr_w0        = rd_cnt;
    assign sram_raddr_w1        = rd_cnt;
    assign sram_raddr_d0        = rd_cnt;
    assign sram_raddr_d1        = rd_cnt;
    assign arr_clear            = clear_q;
    assign arr_en               = en_q;
    assign diag_sel             = diag_q;
    assign sram_write_enable_a0 = we_q;
    assign sram_write_enable_b0 = we_q;
    assign sram_write_enable_c0 = we_q;
    assign sram_waddr_a         = waddr_q;
    assign sram_waddr_b         = waddr_q;
    assign sram_waddr_c         = waddr_q;
    assign tpu_done             = done_q;

endmodule
